// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver with a one-entry
// valid/ready output stage.
//
// Optional feature: define UART_RX_MAJORITY_EN to evaluate each bit as the
// 2-of-3 majority of three samples around mid-bit. Without it, each bit is a
// single sample taken at mid-bit.
//
// Output handshake: valid_out high means data_out holds a byte the consumer
// has not yet taken. A byte is taken on any rising clk_in edge where
// valid_out and ready_in are both high. data_out only changes when a new
// byte is loaded, and a new byte that arrives while an untaken byte is
// blocked (valid_out high, ready_in low) is dropped with an overrun pulse.
module uart_rx #(
    parameter int DATA_BITS         = 8,
    parameter int OVERSAMPLING_RATE = 8
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    input  logic                 divpulse_in,
    input  logic                 rx_in,
    input  logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err_out,
    output logic                 overrun_err_out,
    output logic                 busy_out,
    output logic [1:0]           state_dbg_out
);

    localparam int CNT_W = $clog2(OVERSAMPLING_RATE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int MID   = OVERSAMPLING_RATE / 2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 armed_q, armed_d;
    logic                 deliver;
    logic                 frame_err_d;
    logic                 bit_strobe;
    logic                 bit_val;
    logic                 handshake;

    assign busy_out      = (state_q != IDLE);
    assign state_dbg_out = state_q;
    assign handshake     = valid_out && ready_in;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;

    // Keep the two samples taken just before the deciding tick.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            maj_q <= 2'b00;
        end else if (divpulse_in && (cnt_q == CNT_W'(MID - 1) || cnt_q == CNT_W'(MID))) begin
            maj_q <= {maj_q[0], rx_sync_q};
        end
    end

    assign bit_strobe = divpulse_in && (cnt_q == CNT_W'(MID + 1));
    assign bit_val    = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_sync_q) | (maj_q[0] & rx_sync_q);
`else
    assign bit_strobe = divpulse_in && (cnt_q == CNT_W'(MID));
    assign bit_val    = rx_sync_q;
`endif

    // Receive FSM, counters and shift register state.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
        end
    end

    // Next-state logic: line watching in IDLE, bit evaluation elsewhere.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != IDLE && divpulse_in) begin
            cnt_d = (cnt_q == CNT_W'(OVERSAMPLING_RATE - 1)) ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (divpulse_in) begin
                    if (rx_sync_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d = 1'b0;
                        state_d = START;
                    end
                end
            end
            START: begin
                if (bit_strobe) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    state_d = IDLE;
                    if (bit_val) begin
                        deliver = 1'b1;
                        armed_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: load, hold, drop-with-overrun, and error pulses.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            data_out        <= '0;
            valid_out       <= 1'b0;
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
        end else begin
            frame_err_out   <= frame_err_d;
            overrun_err_out <= 1'b0;
            if (deliver) begin
                if (valid_out && !ready_in) begin
                    overrun_err_out <= 1'b1;
                end else begin
                    data_out  <= shift_q;
                    valid_out <= 1'b1;
                end
            end else if (handshake) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (DATA_BITS=8, 8x oversampling,
// one divpulse_in every 4 clk_in). Honours UART_RX_MAJORITY_EN when defined.
module tb_uart_rx;

    localparam int DB  = 8;
    localparam int OSR = 8;

    logic          clk_in      = 1'b0;
    logic          nrst_in     = 1'b0;
    logic          divpulse_in = 1'b0;
    logic          rx_in       = 1'b1;
    logic          ready_in    = 1'b0;
    logic [DB-1:0] data_out;
    logic          valid_out;
    logic          frame_err_out;
    logic          overrun_err_out;
    logic          busy_out;
    logic [1:0]    state_dbg_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Activity counters and accepted-byte log, written only by the monitor.
    int valid_cycles = 0;
    int ferr_cycles  = 0;
    int ovr_cycles   = 0;
    logic [DB-1:0] got_q[$];
    logic [DB-1:0] exp_q[$];

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLING_RATE(OSR)) dut (
        .clk_in          (clk_in),
        .nrst_in         (nrst_in),
        .divpulse_in     (divpulse_in),
        .rx_in           (rx_in),
        .ready_in        (ready_in),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .frame_err_out   (frame_err_out),
        .overrun_err_out (overrun_err_out),
        .busy_out        (busy_out),
        .state_dbg_out   (state_dbg_out)
    );

    // Clock and reset-independent tick source.
    always #5 clk_in = ~clk_in;

    initial begin
        forever begin
            repeat (3) @(posedge clk_in);
            #1 divpulse_in = 1'b1;
            @(posedge clk_in);
            #1 divpulse_in = 1'b0;
        end
    end

    // Monitor on the falling edge: pulse widths and accepted bytes.
    always @(negedge clk_in) begin
        if (valid_out === 1'b1) valid_cycles++;
        if (frame_err_out === 1'b1) ferr_cycles++;
        if (overrun_err_out === 1'b1) ovr_cycles++;
        if (valid_out === 1'b1 && ready_in === 1'b1) got_q.push_back(data_out);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Expected received byte: a one-tick glitch at mid-bit corrupts that bit
    // when a single sample is taken, and is voted out by 2-of-3 majority.
    function automatic logic [DB-1:0] model_byte(input logic [DB-1:0] d, input int glitch_data_bit);
        logic [DB-1:0] r;
        r = d;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_data_bit >= 0) r[glitch_data_bit] = ~r[glitch_data_bit];
`endif
        return r;
    endfunction

    task automatic wait_tick();
        do @(posedge clk_in); while (divpulse_in !== 1'b1);
        #1;
    endtask

    // Drive one frame, OSR ticks per bit, line left at the stop-bit level.
    // glitch_fb: frame bit index whose 6th tick is inverted (-1 for none).
    // abort_fb:  frame bit index at which to stop driving early (-1 for none).
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit,
                              input int glitch_fb, input int abort_fb);
        logic [DB+1:0] fr;
        fr = {stop_bit, d, 1'b0};
        wait_tick();
        for (int b = 0; b < DB + 2; b++) begin
            for (int t = 0; t < OSR; t++) begin
                if (b == abort_fb && t == 3) return;
                rx_in = fr[b] ^ (b == glitch_fb && t == 5);
                wait_tick();
            end
        end
    endtask

    task automatic test_reset();
        nrst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
        n_checks++; if (frame_err_out !== 1'b0 || overrun_err_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_errs: got %b%b expected 00", frame_err_out, overrun_err_out);
        end
        n_checks++; if (state_dbg_out !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg_out); end
        nrst_in = 1'b1;
        repeat (3) wait_tick();
    endtask

    task automatic test_basic();
        int v0, f0, o0;
        logic [DB-1:0] g;
        ready_in = 1'b1;
        v0 = valid_cycles; f0 = ferr_cycles; o0 = ovr_cycles;
        exp_q.push_back(model_byte(8'hA5, -1));
        send_frame(8'hA5, 1'b1, -1, -1);
        repeat (4) @(posedge clk_in);
        #1;
        n_checks++; if (valid_cycles - v0 !== 1) begin n_fail++; $display("FAIL basic_valid_width: got %0d cycles expected 1", valid_cycles - v0); end
        n_checks++; if (ferr_cycles - f0 !== 0 || ovr_cycles - o0 !== 0) begin
            n_fail++; $display("FAIL basic_errs: got ferr %0d ovr %0d expected 0 0", ferr_cycles - f0, ovr_cycles - o0);
        end
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL basic_count: got %0d bytes expected 1", got_q.size());
            got_q.delete(); exp_q.delete();
        end else begin
            g = got_q.pop_front();
            if (g !== exp_q[0]) begin n_fail++; $display("FAIL basic_data: got %h expected %h", g, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got %h expected a5", data_out); end
    endtask

    task automatic test_glitch();
        int v0, f0, o0;
        v0 = valid_cycles; f0 = ferr_cycles; o0 = ovr_cycles;
        wait_tick();
        rx_in = 1'b0;
        wait_tick();
        wait_tick();
        rx_in = 1'b1;
        n_checks++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL glitch_start_seen: got busy %b expected 1", busy_out); end
        repeat (12) wait_tick();
        n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got busy %b expected 0", busy_out); end
        n_checks++; if (valid_cycles - v0 !== 0 || ferr_cycles - f0 !== 0 || ovr_cycles - o0 !== 0) begin
            n_fail++; $display("FAIL glitch_quiet: got valid %0d ferr %0d ovr %0d expected 0 0 0",
                               valid_cycles - v0, ferr_cycles - f0, ovr_cycles - o0);
        end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        logic [DB-1:0] g;
        ready_in = 1'b1;
        v0 = valid_cycles; f0 = ferr_cycles;
        send_frame(8'h3C, 1'b0, -1, -1);
        repeat (16) wait_tick();
        n_checks++; if (ferr_cycles - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cycles - f0); end
        n_checks++; if (valid_cycles - v0 !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d cycles expected 0", valid_cycles - v0); end
        n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL ferr_held_low: got busy %b expected 0", busy_out); end
        rx_in = 1'b1;
        repeat (2) wait_tick();
        exp_q.push_back(model_byte(8'h55, -1));
        send_frame(8'h55, 1'b1, -1, -1);
        repeat (4) @(posedge clk_in);
        #1;
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL ferr_next_count: got %0d bytes expected 1", got_q.size());
            got_q.delete(); exp_q.delete();
        end else begin
            g = got_q.pop_front();
            if (g !== exp_q[0]) begin n_fail++; $display("FAIL ferr_next_data: got %h expected %h", g, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_overrun();
        int f0, o0;
        logic [DB-1:0] g;
        ready_in = 1'b0;
        f0 = ferr_cycles; o0 = ovr_cycles;
        exp_q.push_back(model_byte(8'h11, -1));
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        repeat (2) @(posedge clk_in);
        #1;
        n_checks++; if (ovr_cycles - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cycles - o0); end
        n_checks++; if (ferr_cycles - f0 !== 0) begin n_fail++; $display("FAIL ovr_no_ferr: got %0d expected 0", ferr_cycles - f0); end
        n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", valid_out); end
        n_checks++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL ovr_data_kept: got %h expected 11", data_out); end
        ready_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL ovr_release: got valid %b expected 0", valid_out); end
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL ovr_count: got %0d bytes expected 1", got_q.size());
            got_q.delete(); exp_q.delete();
        end else begin
            g = got_q.pop_front();
            if (g !== exp_q[0]) begin n_fail++; $display("FAIL ovr_accept: got %h expected %h", g, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        int v0, f0, o0;
        logic [DB-1:0] g;
        ready_in = 1'b1;
        send_frame(8'hFF, 1'b1, -1, 5);
        n_checks++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_out); end
        nrst_in = 1'b0;
        #2;
        n_checks++; if (data_out !== 8'h00 || valid_out !== 1'b0 || busy_out !== 1'b0 ||
                        frame_err_out !== 1'b0 || overrun_err_out !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: got data %h valid %b busy %b ferr %b ovr %b expected all 0",
                               data_out, valid_out, busy_out, frame_err_out, overrun_err_out);
        end
        rx_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 nrst_in = 1'b1;
        v0 = valid_cycles; f0 = ferr_cycles; o0 = ovr_cycles;
        repeat (12) wait_tick();
        n_checks++; if (valid_cycles - v0 !== 0 || ferr_cycles - f0 !== 0 || ovr_cycles - o0 !== 0 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_quiet: got valid %0d ferr %0d ovr %0d busy %b expected 0 0 0 0",
                               valid_cycles - v0, ferr_cycles - f0, ovr_cycles - o0, busy_out);
        end
        exp_q.push_back(model_byte(8'h81, -1));
        send_frame(8'h81, 1'b1, -1, -1);
        repeat (4) @(posedge clk_in);
        #1;
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL rstmid_next_count: got %0d bytes expected 1", got_q.size());
            got_q.delete(); exp_q.delete();
        end else begin
            g = got_q.pop_front();
            if (g !== exp_q[0]) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected %h", g, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_majority();
        logic [DB-1:0] g;
        ready_in = 1'b1;
        exp_q.push_back(model_byte(8'h00, 2));
        send_frame(8'h00, 1'b1, 3, -1);
        repeat (4) @(posedge clk_in);
        #1;
        n_checks++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL majority_count: got %0d bytes expected 1", got_q.size());
            got_q.delete(); exp_q.delete();
        end else begin
            g = got_q.pop_front();
            if (g !== exp_q[0]) begin n_fail++; $display("FAIL majority_data: got %h expected %h", g, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_random();
        int f0, o0, cyc;
        logic [DB-1:0] d, g;
        f0 = ferr_cycles; o0 = ovr_cycles;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom_range(0, 255));
            ready_in = 1'($urandom_range(0, 1));
            exp_q.push_back(model_byte(d, -1));
            send_frame(d, 1'b1, -1, -1);
            cyc = 0;
            while (got_q.size() == 0 && cyc < 200) begin
                @(posedge clk_in);
                #1 ready_in = 1'($urandom_range(0, 1));
                cyc++;
            end
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++; $display("FAIL random_timeout: frame %0d got no byte in %0d cycles expected %h", i, cyc, exp_q[0]);
                exp_q.delete();
            end else begin
                g = got_q.pop_front();
                if (g !== exp_q[0]) begin n_fail++; $display("FAIL random_data: frame %0d got %h expected %h", i, g, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        n_checks++; if (ferr_cycles - f0 !== 0 || ovr_cycles - o0 !== 0) begin
            n_fail++; $display("FAIL random_errs: got ferr %0d ovr %0d expected 0 0", ferr_cycles - f0, ovr_cycles - o0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_majority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
